// File: rtl/switch_debouncer.sv
// Four-channel slide-switch conditioner: two-flop synchroniser, then a per-channel
// IDLE/CHECK debounce FSM producing clean levels and registered rise/fall pulses.
module switch_debouncer #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH     = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             all_stable
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]     sync1_q;
    logic [WIDTH-1:0]     sync2_q;
    logic [WIDTH-1:0]     switches_q;
    logic [WIDTH-1:0]     rise_q;
    logic [WIDTH-1:0]     fall_q;
    state_e               state_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_q   [WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= switches_raw;
            sync2_q <= sync1_q;
        end
    end

    // The IDLE->CHECK edge is not counted, so acceptance lands STABLE_CYCLES+1
    // edges after sync2 first differs (STABLE_CYCLES+2 after raw is sampled).
    always_ff @(posedge clk) begin
        if (reset) begin
            switches_q <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                case (state_q[i])
                    IDLE: begin
                        cnt_q[i] <= '0;
                        if (sync2_q[i] != switches_q[i]) begin
                            state_q[i] <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (sync2_q[i] == switches_q[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= IDLE;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            switches_q[i] <= sync2_q[i];
                            rise_q[i]     <= sync2_q[i];
                            fall_q[i]     <= ~sync2_q[i];
                            cnt_q[i]      <= '0;
                            state_q[i]    <= IDLE;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        cnt_q[i]   <= '0;
                        state_q[i] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign switches   = switches_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign all_stable = &(sync2_q ~^ switches_q);

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised + directed bench for switch_debouncer; a run-length reference model
// pushes per-cycle expectations that an independent monitor pops and compares.
module tb_switch_debouncer;

    localparam int unsigned S = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] switches_raw = 4'b1010;
    logic [3:0] switches;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       all_stable;

    int n_chk = 0;
    int n_fail = 0;
    bit started = 1'b0;

    logic [12:0] exp_q [$];

    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    logic [3:0] m_sw = '0;
    int         m_run [4];

    switch_debouncer #(
        .WIDTH(4),
        .STABLE_CYCLES(S),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switches_raw(switches_raw),
        .switches(switches),
        .rise(rise),
        .fall(fall),
        .all_stable(all_stable)
    );

    always #5 clk = ~clk;

    // Model: raw reaches the debouncer two edges late; a channel flips once its
    // delayed input has disagreed with the debounced level for S+1 straight edges.
    task automatic step(input logic rst, input logic [3:0] raw);
        logic [3:0] r;
        logic [3:0] f;
        @(negedge clk);
        reset = rst;
        switches_raw = raw;
        r = '0;
        f = '0;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_sw = '0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_s2[k] != m_sw[k]) begin
                    m_run[k]++;
                    if (m_run[k] == S + 1) begin
                        m_sw[k] = m_s2[k];
                        if (m_s2[k]) r[k] = 1'b1;
                        else f[k] = 1'b1;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        exp_q.push_back({m_sw, r, f, &(m_s2 ~^ m_sw)});
        started = 1'b1;
    endtask

    task automatic hold(input logic rst, input logic [3:0] raw, input int n);
        for (int k = 0; k < n; k++) step(rst, raw);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        logic [12:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow at %0t: got 0 entries expected >=1", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("switches", switches, e[12:9]);
                    chk("rise", rise, e[8:5]);
                    chk("fall", fall, e[4:1]);
                    chk("all_stable", {3'b000, all_stable}, {3'b000, e[0]});
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [3:0] cur;
        logic [3:0] g;
        for (int k = 0; k < 4; k++) m_run[k] = 0;

        hold(1'b1, 4'b1010, 3);          // reset with switches present
        hold(1'b0, 4'b0000, 12);
        hold(1'b0, 4'b0001, 14);         // clean rise on bit0
        hold(1'b0, 4'b0101, 5);          // 5-cycle glitch on bit2
        hold(1'b0, 4'b0001, 12);
        hold(1'b0, 4'b1111, 14);
        hold(1'b0, 4'b0110, 14);         // fall on bits 3 and 0
        hold(1'b0, 4'b0000, 14);
        hold(1'b0, 4'b0001, 3);          // staggered independent channels
        hold(1'b0, 4'b1001, 16);
        hold(1'b0, 4'b0000, 14);
        hold(1'b0, 4'b0100, 7);          // reset mid-count
        hold(1'b1, 4'b0100, 1);
        hold(1'b0, 4'b0100, 16);
        for (int k = 0; k < 40; k++) step(1'b0, (k % 2 == 0) ? 4'b0000 : 4'b1111);
        hold(1'b0, 4'b0100, 14);

        cur = 4'b0100;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, cur);
            end else begin
                if ($urandom_range(0, 11) == 0) cur = 4'($urandom);
                if ($urandom_range(0, 29) == 0) begin
                    g = cur;
                    g[$urandom_range(0, 3)] ^= 1'b1;
                    step(1'b0, g);
                end else begin
                    step(1'b0, cur);
                end
            end
        end

        @(posedge clk);
        #2;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream stage for the switch-to-lights reduction logic. It conditions the four raw slide switches before they drive that logic.
- Each switch input is synchronised, then debounced per channel. The block outputs a clean 4-bit switch vector plus per-bit rise/fall pulses.
- The reduction stage consumes the debounced switch vector directly; the pulses are available for future counters and LED sequencers.

Parameters:
- WIDTH, 4, number of switch channels.
- STABLE_CYCLES, 1000000, consecutive clocks the synchronised input must differ from the debounced value before the change is accepted (10 ms at 100 MHz). Legal range 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 20, width of each per-channel stability counter.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- switches_raw  input  WIDTH  asynchronous raw switch levels.
- switches  output  WIDTH  debounced switch levels; feeds the reduction stage.
- rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- all_stable  output  1  high when no channel has a pending change.

Behaviour:
- Reset (sampled on the clk rising edge while reset=1):
  - Clears both synchroniser stages, switches, rise, fall and all counters to 0.
  - all_stable reads 1 during and after reset.
  - Reset asserted mid-count discards the pending change. A switch held high through reset is re-accepted STABLE_CYCLES+2 clocks after reset deasserts, and produces a rise pulse.
- Synchroniser: two flops per bit, sync1 <= switches_raw, sync2 <= sync1. Only sync2 is used downstream.
- Per-channel state machine, 2 states, each channel independent:
  - IDLE: sync2 == switches[i], counter = 0. Enter CHECK when sync2 != switches[i].
  - CHECK: counter increments each clock while sync2 != switches[i].
    - If sync2 returns equal to switches[i] on any clock (glitch): counter <= 0, return to IDLE, no output change, no pulse.
    - If sync2 != switches[i] and counter == STABLE_CYCLES-1: on that edge switches[i] <= sync2, counter <= 0, return to IDLE, and assert rise[i] (new value 1) or fall[i] (new value 0).
- Pulses:
  - rise and fall are registered and high for exactly one clock, the same clock switches[i] first shows the new value.
  - rise[i] and fall[i] are never both high.
  - Pulses on different channels may coincide.
- Latency: a clean raw step held stable appears on switches exactly STABLE_CYCLES+2 clocks after the first clk edge that samples it.
- Counter never wraps: it is cleared at STABLE_CYCLES-1 or on a glitch. Parameter legality guarantees it fits in CNT_WIDTH.
- all_stable: combinational AND over channels of (sync2 == switches). It is 0 for every clock a channel is in CHECK.
- Simultaneous changes on several channels are debounced independently with identical timing.
- switches_raw toggling every clock never changes switches and produces no pulses.

Test Plan:
Benches use STABLE_CYCLES=8.
- Reset: hold reset 3 clocks with switches_raw=4'b1010 -> switches=0, rise=0, fall=0, all_stable=1 throughout reset.
- Clean step: after reset, switches_raw 0000->0001 at edge N -> switches=0001 and rise=0001 at edge N+10. rise is low at N+11; all_stable is low from N+2 through N+9.
- Glitch rejection: raw bit2 high for 5 clocks then low -> switches stays 0000, no pulses, all_stable returns to 1.
- Fall: from switches=1111, raw -> 0110 -> switches=0110 and fall=1001 for exactly one clock, rise=0000.
- Independent channels: bit0 set at edge N and bit3 set at edge N+3 -> rise=0001 at N+10 and rise=1000 at N+13; switches=1001 thereafter.
- Reset mid-count: raw=0100, reset asserted at count 5 for 1 clock -> switches stays 0. After deassert, switches=0100 with a rise pulse 10 clocks later.
